// File: rtl/tl_phase_scheduler.sv
`default_nettype none
// ============================================================================
// tl_phase_scheduler : traffic-light phase sequencer with setup-mode editing
// Revision 1.0
// ============================================================================
module tl_phase_scheduler #(
  parameter int TICK_DIV  = 25000000,
  parameter int RED_SEC   = 2,
  parameter int FLASH_SEC = 3,
  parameter int MIN_GREEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       buttonU,
  input  logic       buttonD,
  input  logic       buttonL,
  input  logic       buttonR,
  input  logic       ped_req,
  output logic [2:0] cur_phase,
  output logic [3:0] seven_num,
  output logic       ped_pending,
  output logic [1:0] sel
);

  localparam int                 C_CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_TICK_LAST = C_CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]         C_RED_SEC   = 4'(RED_SEC);
  localparam logic [3:0]         C_FLASH_SEC = 4'(FLASH_SEC);
  localparam logic [3:0]         C_MIN_GREEN = 4'(MIN_GREEN);
  localparam logic [3:0]         C_DUR_MAX   = 4'd9;
  localparam logic [3:0]         C_DUR_MIN   = 4'd1;

  typedef enum logic [2:0] {
    PH_GREEN  = 3'd0,
    PH_YELLOW = 3'd1,
    PH_RED_A  = 3'd2,
    PH_WALK   = 3'd3,
    PH_FLASH  = 3'd4,
    PH_RED_B  = 3'd5,
    PH_SETUP  = 3'd7
  } phase_t;

  phase_t               r_phase, w_phase_nxt, w_succ;
  logic [3:0]           r_rem, w_rem_nxt, w_succ_dur;
  logic [C_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic                 r_ped, w_ped_nxt;
  logic [1:0]           r_sel, w_sel_nxt;
  logic [3:0]           r_dur_g, r_dur_y, r_dur_w;
  logic [3:0]           w_dur_g_nxt, w_dur_y_nxt, w_dur_w_nxt;
  logic [3:0]           w_sel_dur, w_edit_dur;
  logic                 w_tick, w_ped_ok;

  // Successor phase and the duration it starts with
  always_comb begin
    w_succ     = PH_GREEN;
    w_succ_dur = r_dur_g;
    case (r_phase)
      PH_GREEN:  begin w_succ = PH_YELLOW; w_succ_dur = r_dur_y;     end
      PH_YELLOW: begin w_succ = PH_RED_A;  w_succ_dur = C_RED_SEC;   end
      PH_RED_A:  if (r_ped) begin w_succ = PH_WALK; w_succ_dur = r_dur_w; end
      PH_WALK:   begin w_succ = PH_FLASH;  w_succ_dur = C_FLASH_SEC; end
      PH_FLASH:  begin w_succ = PH_RED_B;  w_succ_dur = C_RED_SEC;   end
      default:   ;
    endcase
  end

  always_comb begin
    case (r_sel)
      2'd1:    w_sel_dur = r_dur_y;
      2'd2:    w_sel_dur = r_dur_w;
      default: w_sel_dur = r_dur_g;
    endcase
    w_edit_dur = w_sel_dur;
    if (buttonU && !buttonD && (w_sel_dur < C_DUR_MAX))
      w_edit_dur = w_sel_dur + 4'd1;
    else if (buttonD && !buttonU && (w_sel_dur > C_DUR_MIN))
      w_edit_dur = w_sel_dur - 4'd1;
  end

  assign w_tick   = (r_cnt == C_TICK_LAST);
  assign w_ped_ok = (r_phase == PH_GREEN) || (r_phase == PH_YELLOW) ||
                    (r_phase == PH_RED_A) || (r_phase == PH_RED_B);

  always_comb begin
    w_phase_nxt = r_phase;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_ped_nxt   = r_ped;
    w_sel_nxt   = r_sel;
    w_dur_g_nxt = r_dur_g;
    w_dur_y_nxt = r_dur_y;
    w_dur_w_nxt = r_dur_w;

    if (r_phase == PH_SETUP) begin
      w_cnt_nxt = '0;
      w_ped_nxt = 1'b0;
      if (!set) begin
        w_phase_nxt = PH_GREEN;
        w_rem_nxt   = r_dur_g;
      end else begin
        // Display trails the edited register by one cycle
        w_rem_nxt = w_sel_dur;
        case (r_sel)
          2'd1:    w_dur_y_nxt = w_edit_dur;
          2'd2:    w_dur_w_nxt = w_edit_dur;
          default: w_dur_g_nxt = w_edit_dur;
        endcase
        if (buttonR && !buttonL)
          w_sel_nxt = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
        else if (buttonL && !buttonR)
          w_sel_nxt = (r_sel == 2'd0) ? 2'd2 : r_sel - 2'd1;
      end
    end else if (set) begin
      w_phase_nxt = PH_SETUP;
      w_rem_nxt   = w_sel_dur;
      w_cnt_nxt   = '0;
      w_ped_nxt   = 1'b0;
    end else begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
      if (ped_req && w_ped_ok)
        w_ped_nxt = 1'b1;
      // Truncation keeps the running tick phase; only rem is shortened
      if (ped_req && (r_phase == PH_GREEN) && (r_rem > C_MIN_GREEN)) begin
        w_rem_nxt = C_MIN_GREEN;
      end else if (w_tick) begin
        if (r_rem == 4'd1) begin
          w_phase_nxt = w_succ;
          w_rem_nxt   = w_succ_dur;
          w_cnt_nxt   = '0;
          if (w_succ == PH_WALK)
            w_ped_nxt = 1'b0;
        end else begin
          w_rem_nxt = r_rem - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= PH_GREEN;
      r_rem   <= 4'd9;
      r_cnt   <= '0;
      r_ped   <= 1'b0;
      r_sel   <= 2'd0;
      r_dur_g <= 4'd9;
      r_dur_y <= 4'd3;
      r_dur_w <= 4'd7;
    end else begin
      r_phase <= w_phase_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ped   <= w_ped_nxt;
      r_sel   <= w_sel_nxt;
      r_dur_g <= w_dur_g_nxt;
      r_dur_y <= w_dur_y_nxt;
      r_dur_w <= w_dur_w_nxt;
    end
  end

  assign cur_phase   = r_phase;
  assign seven_num   = r_rem;
  assign ped_pending = r_ped;
  assign sel         = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_tl_phase_scheduler.sv
`default_nettype none
// ============================================================================
// tb_tl_phase_scheduler : scoreboard bench for the traffic-light phase sequencer
// Revision 1.0
// ============================================================================
module tb_tl_phase_scheduler;

  localparam logic [2:0] P_G  = 3'd0;
  localparam logic [2:0] P_Y  = 3'd1;
  localparam logic [2:0] P_RA = 3'd2;
  localparam logic [2:0] P_W  = 3'd3;
  localparam logic [2:0] P_F  = 3'd4;
  localparam logic [2:0] P_RB = 3'd5;
  localparam logic [2:0] P_S  = 3'd7;

  logic       clk, rst, set, buttonU, buttonD, buttonL, buttonR, ped_req;
  logic [2:0] cur_phase;
  logic [3:0] seven_num;
  logic       ped_pending;
  logic [1:0] sel;

  typedef struct packed {
    logic [3:0] id;
    logic [2:0] phase;
    logic [3:0] num;
    logic       ped;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  logic [3:0] test_id = 4'd0;

  tl_phase_scheduler #(
    .TICK_DIV(4), .RED_SEC(2), .FLASH_SEC(3), .MIN_GREEN(3)
  ) dut (
    .clk(clk), .rst(rst), .set(set),
    .buttonU(buttonU), .buttonD(buttonD), .buttonL(buttonL), .buttonR(buttonR),
    .ped_req(ped_req),
    .cur_phase(cur_phase), .seven_num(seven_num),
    .ped_pending(ped_pending), .sel(sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    checks++;
    if (cur_phase !== e.phase || seven_num !== e.num || ped_pending !== e.ped || sel !== e.sel) begin
      errors++;
      $display("FAIL t%0d step %0d: got phase=%0d num=%0d ped=%0d sel=%0d, want phase=%0d num=%0d ped=%0d sel=%0d",
               e.id, step_no, cur_phase, seven_num, ped_pending, sel, e.phase, e.num, e.ped, e.sel);
    end
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        step_no++;
        compare(exp_q.pop_front());
      end
    end
  end

  task automatic check_now(input logic [2:0] p, input logic [3:0] n, input logic pd, input logic [1:0] sl);
    exp_t e;
    e = '{id: test_id, phase: p, num: n, ped: pd, sel: sl};
    compare(e);
  endtask

  // Queue the state expected after the coming edge, then release pulses
  task automatic step(input logic [2:0] p, input logic [3:0] n, input logic pd, input logic [1:0] sl);
    exp_t e;
    e = '{id: test_id, phase: p, num: n, ped: pd, sel: sl};
    exp_q.push_back(e);
    @(negedge clk);
    buttonU = 1'b0; buttonD = 1'b0; buttonL = 1'b0; buttonR = 1'b0; ped_req = 1'b0;
  endtask

  // Samples j0..j1-1 of a phase of d seconds entered at sample 0
  task automatic run_phase(input logic [2:0] p, input int d, input logic pd, input logic [1:0] sl,
                           input int j0, input int j1);
    for (int j = j0; j < j1; j++)
      step(p, 4'(d - j / 4), pd, sl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; set = 1'b0; ped_req = 1'b0;
    buttonU = 1'b0; buttonD = 1'b0; buttonL = 1'b0; buttonR = 1'b0;

    // 1: reset state and plain cycle without requests
    test_id = 4'd1;
    repeat (2) @(negedge clk);
    check_now(P_G, 4'd9, 1'b0, 2'd0);
    rst = 1'b1;
    run_phase(P_G, 9, 1'b0, 2'd0, 1, 36);
    run_phase(P_Y, 3, 1'b0, 2'd0, 0, 12);
    run_phase(P_RA, 2, 1'b0, 2'd0, 0, 8);

    // 2: request at rem=8 truncates green, walk sequence follows
    test_id = 4'd2;
    run_phase(P_G, 9, 1'b0, 2'd0, 0, 5);
    ped_req = 1'b1;
    step(P_G, 4'd3, 1'b1, 2'd0);
    run_phase(P_G, 3, 1'b1, 2'd0, 2, 12);
    run_phase(P_Y, 3, 1'b1, 2'd0, 0, 12);
    run_phase(P_RA, 2, 1'b1, 2'd0, 0, 8);
    run_phase(P_W, 7, 1'b0, 2'd0, 0, 28);
    run_phase(P_F, 3, 1'b0, 2'd0, 0, 12);
    run_phase(P_RB, 2, 1'b0, 2'd0, 0, 8);

    // 3: request during walk is ignored; request at RED_A decision goes to green
    test_id = 4'd3;
    step(P_G, 4'd9, 1'b0, 2'd0);
    ped_req = 1'b1;
    step(P_G, 4'd3, 1'b1, 2'd0);
    run_phase(P_G, 3, 1'b1, 2'd0, 2, 12);
    run_phase(P_Y, 3, 1'b1, 2'd0, 0, 12);
    run_phase(P_RA, 2, 1'b1, 2'd0, 0, 8);
    run_phase(P_W, 7, 1'b0, 2'd0, 0, 3);
    ped_req = 1'b1;
    step(P_W, 4'd7, 1'b0, 2'd0);
    run_phase(P_W, 7, 1'b0, 2'd0, 4, 28);
    run_phase(P_F, 3, 1'b0, 2'd0, 0, 12);
    run_phase(P_RB, 2, 1'b0, 2'd0, 0, 8);
    run_phase(P_G, 9, 1'b0, 2'd0, 0, 36);
    run_phase(P_Y, 3, 1'b0, 2'd0, 0, 12);
    run_phase(P_RA, 2, 1'b0, 2'd0, 0, 8);
    ped_req = 1'b1;
    step(P_G, 4'd9, 1'b1, 2'd0);
    run_phase(P_G, 9, 1'b1, 2'd0, 1, 6);

    // 4: setup editing with saturation; setup entry clears pending
    test_id = 4'd4;
    set = 1'b1;
    step(P_S, 4'd9, 1'b0, 2'd0);
    buttonR = 1'b1;
    step(P_S, 4'd9, 1'b0, 2'd1);
    for (int i = 1; i <= 10; i++) begin
      buttonU = 1'b1;
      step(P_S, 4'((2 + i > 9) ? 9 : 2 + i), 1'b0, 2'd1);
    end
    buttonL = 1'b1;
    step(P_S, 4'd9, 1'b0, 2'd0);
    for (int i = 1; i <= 12; i++) begin
      buttonD = 1'b1;
      step(P_S, 4'((10 - i < 1) ? 1 : 10 - i), 1'b0, 2'd0);
    end
    step(P_S, 4'd1, 1'b0, 2'd0);

    // 5: simultaneous buttons, selection wrap, ped_req ignored in setup
    test_id = 4'd5;
    buttonU = 1'b1; buttonD = 1'b1;
    step(P_S, 4'd1, 1'b0, 2'd0);
    buttonL = 1'b1; buttonR = 1'b1;
    step(P_S, 4'd1, 1'b0, 2'd0);
    step(P_S, 4'd1, 1'b0, 2'd0);
    buttonL = 1'b1;
    step(P_S, 4'd1, 1'b0, 2'd2);
    ped_req = 1'b1;
    step(P_S, 4'd7, 1'b0, 2'd2);
    buttonR = 1'b1;
    step(P_S, 4'd7, 1'b0, 2'd0);
    step(P_S, 4'd1, 1'b0, 2'd0);
    buttonR = 1'b1;
    step(P_S, 4'd1, 1'b0, 2'd1);
    step(P_S, 4'd9, 1'b0, 2'd1);
    buttonL = 1'b1;
    step(P_S, 4'd9, 1'b0, 2'd0);
    step(P_S, 4'd1, 1'b0, 2'd0);

    // 6: exit setup with edited durations; request at rem<=MIN_GREEN keeps rem
    test_id = 4'd6;
    set = 1'b0;
    step(P_G, 4'd1, 1'b0, 2'd0);
    ped_req = 1'b1;
    step(P_G, 4'd1, 1'b1, 2'd0);
    run_phase(P_G, 1, 1'b1, 2'd0, 2, 4);
    run_phase(P_Y, 9, 1'b1, 2'd0, 0, 4);
    buttonU = 1'b1; buttonR = 1'b1;
    step(P_Y, 4'd8, 1'b1, 2'd0);
    run_phase(P_Y, 9, 1'b1, 2'd0, 5, 36);
    run_phase(P_RA, 2, 1'b1, 2'd0, 0, 8);
    run_phase(P_W, 7, 1'b0, 2'd0, 0, 6);

    // 7: asynchronous reset mid-walk reverts everything
    test_id = 4'd7;
    #2 rst = 1'b0;
    #1 check_now(P_G, 4'd9, 1'b0, 2'd0);
    @(negedge clk);
    check_now(P_G, 4'd9, 1'b0, 2'd0);
    rst = 1'b1;
    set = 1'b1;
    step(P_S, 4'd9, 1'b0, 2'd0);
    buttonR = 1'b1;
    step(P_S, 4'd9, 1'b0, 2'd1);
    step(P_S, 4'd3, 1'b0, 2'd1);
    buttonR = 1'b1;
    step(P_S, 4'd3, 1'b0, 2'd2);
    step(P_S, 4'd7, 1'b0, 2'd2);
    set = 1'b0;
    step(P_G, 4'd9, 1'b0, 2'd2);
    step(P_G, 4'd9, 1'b0, 2'd2);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
